// File: rtl/rice_core_hazard_controller_if.sv
// Handshake bundle between the IF/ID/EX pipeline and the hazard controller.
// RICE_CORE_HAZARD_STAT_EN adds the o_stall_count statistics output.
interface rice_core_hazard_controller_if;
   logic        i_id_valid;
   logic [4:0]  i_id_rs1;
   logic [4:0]  i_id_rs2;
   logic        i_ex_valid;
   logic        i_ex_load;
   logic [4:0]  i_ex_rd;
   logic        i_wb_valid;
   logic [4:0]  i_wb_rd;
   logic        i_redirect;
   logic        i_trap;
   logic        i_mem_idle;
   logic        o_enable;
   logic        o_stall;
   logic        o_flush;
   logic        o_busy;
`ifdef RICE_CORE_HAZARD_STAT_EN
   logic [31:0] o_stall_count;

   modport master (
      output i_id_valid, i_id_rs1, i_id_rs2, i_ex_valid, i_ex_load, i_ex_rd,
             i_wb_valid, i_wb_rd, i_redirect, i_trap, i_mem_idle,
      input  o_enable, o_stall, o_flush, o_busy, o_stall_count
   );
   modport slave (
      input  i_id_valid, i_id_rs1, i_id_rs2, i_ex_valid, i_ex_load, i_ex_rd,
             i_wb_valid, i_wb_rd, i_redirect, i_trap, i_mem_idle,
      output o_enable, o_stall, o_flush, o_busy, o_stall_count
   );
`else
   modport master (
      output i_id_valid, i_id_rs1, i_id_rs2, i_ex_valid, i_ex_load, i_ex_rd,
             i_wb_valid, i_wb_rd, i_redirect, i_trap, i_mem_idle,
      input  o_enable, o_stall, o_flush, o_busy
   );
   modport slave (
      input  i_id_valid, i_id_rs1, i_id_rs2, i_ex_valid, i_ex_load, i_ex_rd,
             i_wb_valid, i_wb_rd, i_redirect, i_trap, i_mem_idle,
      output o_enable, o_stall, o_flush, o_busy
   );
`endif
endinterface

// File: rtl/rice_core_hazard_controller.sv
// ID-stage hazard sequencer: load-use scoreboard, startup, redirect flush and trap drain.
// RICE_CORE_HAZARD_STAT_EN adds a saturating stall-cycle counter (o_stall_count).
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   STARTUP  | post-reset wait, o_enable low for STARTUP_CYCLES cycles
//   RUN      | normal issue, load-use stalls evaluated
//   FLUSH    | o_flush high for FLUSH_CYCLES cycles after a redirect/drain
//   DRAIN    | trap taken, o_flush high until loads retired and bus idle
module rice_core_hazard_controller #(
   parameter int STARTUP_CYCLES = 2,
   parameter int FLUSH_CYCLES   = 1
) (
   input logic                           i_clk,
   input logic                           i_rst_n,
   rice_core_hazard_controller_if.slave  bus
);

   typedef enum logic [1:0] {
      ST_STARTUP = 2'd0,
      ST_RUN     = 2'd1,
      ST_FLUSH   = 2'd2,
      ST_DRAIN   = 2'd3
   } state_t;

   localparam int CNT_MAX = (STARTUP_CYCLES > FLUSH_CYCLES) ? STARTUP_CYCLES : FLUSH_CYCLES;
   localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);
   localparam logic [CNT_W-1:0] STARTUP_TC = CNT_W'(STARTUP_CYCLES - 1);
   localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES - 1);

   state_t             r_state;
   state_t             w_state_nxt;
   logic [CNT_W-1:0]   r_cnt;
   logic [CNT_W-1:0]   w_cnt_nxt;
   logic [31:0]        r_sb;
   logic [31:0]        w_wb_clr;
   logic [31:0]        w_sb_set;
   logic [31:0]        w_sb_fwd;
   logic               w_ex_ld;
   logic               w_hit1;
   logic               w_hit2;
   logic               w_run;
   logic               w_enable;
   logic               w_flush;
   logic               w_stall;

   // STARTUP counts up to its terminal value; FLUSH counts down to zero.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_enable    = 1'b1;
      w_flush     = 1'b0;
      w_run       = 1'b0;
      case (r_state)
         ST_STARTUP: begin
            w_enable = 1'b0;
            if (r_cnt == STARTUP_TC) begin
               w_state_nxt = ST_RUN;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         ST_RUN: begin
            w_run = 1'b1;
            if (bus.i_trap) begin
               w_state_nxt = ST_DRAIN;
            end else if (bus.i_redirect) begin
               w_state_nxt = ST_FLUSH;
               w_cnt_nxt   = FLUSH_LOAD;
            end
         end
         ST_FLUSH: begin
            w_flush = 1'b1;
            if (bus.i_trap) begin
               w_state_nxt = ST_DRAIN;
            end else if (r_cnt == '0) begin
               w_state_nxt = ST_RUN;
            end else begin
               w_cnt_nxt = r_cnt - 1'b1;
            end
         end
         ST_DRAIN: begin
            w_flush = 1'b1;
            if ((r_sb == '0) && bus.i_mem_idle) begin
               w_state_nxt = ST_FLUSH;
               w_cnt_nxt   = FLUSH_LOAD;
            end
         end
         default: begin
            w_state_nxt = ST_STARTUP;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= ST_STARTUP;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // A writeback this cycle is forwarded by the register file, so it no longer blocks ID.
   assign w_wb_clr = bus.i_wb_valid ? (32'd1 << bus.i_wb_rd) : 32'd0;
   assign w_sb_fwd = r_sb & ~w_wb_clr;
   assign w_ex_ld  = bus.i_ex_valid && bus.i_ex_load && (bus.i_ex_rd != 5'd0);
   assign w_hit1   = w_sb_fwd[bus.i_id_rs1] || (w_ex_ld && (bus.i_ex_rd == bus.i_id_rs1));
   assign w_hit2   = w_sb_fwd[bus.i_id_rs2] || (w_ex_ld && (bus.i_ex_rd == bus.i_id_rs2));
   assign w_stall  = w_run && bus.i_id_valid && (w_hit1 || w_hit2);
   assign w_sb_set = (w_ex_ld && !w_stall && !w_flush) ? (32'd1 << bus.i_ex_rd) : 32'd0;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sb <= '0;
      end else begin
         r_sb <= ((r_sb & ~w_wb_clr) | w_sb_set) & ~32'd1;
      end
   end

   assign bus.o_enable = w_enable;
   assign bus.o_stall  = w_stall;
   assign bus.o_flush  = w_flush;
   assign bus.o_busy   = !w_run;

`ifdef RICE_CORE_HAZARD_STAT_EN
   logic [31:0] r_stall_count;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_stall_count <= '0;
      end else if (w_stall && (r_stall_count != 32'hFFFF_FFFF)) begin
         r_stall_count <= r_stall_count + 32'd1;
      end
   end

   assign bus.o_stall_count = r_stall_count;
`endif

endmodule

// File: tb/tb_rice_core_hazard_controller.sv
// Self-checking bench for rice_core_hazard_controller: directed scenarios plus a
// random run compared against a behavioural model of the sequencing rules.
module tb_rice_core_hazard_controller;
   localparam int STARTUP_CYCLES = 2;
   localparam int FLUSH_CYCLES   = 1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   rice_core_hazard_controller_if bus();

   rice_core_hazard_controller #(
      .STARTUP_CYCLES(STARTUP_CYCLES),
      .FLUSH_CYCLES(FLUSH_CYCLES)
   ) dut (
      .i_clk(clk),
      .i_rst_n(rst_n),
      .bus(bus)
   );

   int total = 0;
   int bad = 0;

   // model: mode 0=startup 1=run 2=flush 3=drain, m_left = cycles remaining in mode
   int   m_mode;
   int   m_left;
   bit   m_pend[32];
   logic m_en, m_st, m_fl, m_busy;

   function automatic bit m_hit(input logic [4:0] rs);
      if (rs == 5'd0) return 1'b0;
      if (m_pend[rs] && !(bus.i_wb_valid && bus.i_wb_rd == rs)) return 1'b1;
      return bus.i_ex_valid && bus.i_ex_load && (bus.i_ex_rd == rs);
   endfunction

   function automatic void model_eval();
      m_en   = (m_mode != 0);
      m_busy = (m_mode != 1);
      m_fl   = (m_mode >= 2);
      m_st   = (m_mode == 1) && bus.i_id_valid && (m_hit(bus.i_id_rs1) || m_hit(bus.i_id_rs2));
   endfunction

   function automatic void model_commit();
      bit any_pend = 1'b0;
      model_eval();
      for (int i = 0; i < 32; i++) any_pend |= m_pend[i];
      case (m_mode)
         0: if (m_left == 1) m_mode = 1; else m_left--;
         1: if (bus.i_trap) m_mode = 3;
            else if (bus.i_redirect) begin m_mode = 2; m_left = FLUSH_CYCLES; end
         2: if (bus.i_trap) m_mode = 3;
            else if (m_left == 1) m_mode = 1;
            else m_left--;
         default: if (!any_pend && bus.i_mem_idle) begin m_mode = 2; m_left = FLUSH_CYCLES; end
      endcase
      if (bus.i_wb_valid) m_pend[bus.i_wb_rd] = 1'b0;
      if (bus.i_ex_valid && bus.i_ex_load && bus.i_ex_rd != 5'd0 && !m_st && !m_fl)
         m_pend[bus.i_ex_rd] = 1'b1;
   endfunction

   function automatic void model_reset();
      m_mode = 0;
      m_left = STARTUP_CYCLES;
      for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
   endfunction

   task automatic idle_inputs();
      bus.i_id_valid = 0; bus.i_id_rs1 = 0; bus.i_id_rs2 = 0;
      bus.i_ex_valid = 0; bus.i_ex_load = 0; bus.i_ex_rd = 0;
      bus.i_wb_valid = 0; bus.i_wb_rd = 0;
      bus.i_redirect = 0; bus.i_trap = 0; bus.i_mem_idle = 1;
   endtask

   task automatic settle();
      #1;
      model_eval();
   endtask

   task automatic tick();
      model_commit();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      idle_inputs();
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic wait_run(input string tag);
      for (int i = 0; i < 10 && m_mode != 1; i++) tick();
      settle();
      total++;
      if (bus.o_enable !== 1'b1) begin
         bad++;
         $display("FAIL %s_run_timeout enable got=%b exp=1", tag, bus.o_enable);
      end
   endtask

   task automatic test_reset();
      logic [1:0] exp_eb [3] = '{2'b01, 2'b01, 2'b10};
      idle_inputs();
      model_reset();
      #2;
      total++;
      if ({bus.o_enable, bus.o_stall, bus.o_flush, bus.o_busy} !== 4'b0001) begin
         bad++;
         $display("FAIL reset_hold got=%b exp=0001", {bus.o_enable, bus.o_stall, bus.o_flush, bus.o_busy});
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         settle();
         total++;
         if ({bus.o_enable, bus.o_busy} !== exp_eb[c]) begin
            bad++;
            $display("FAIL reset_cycle%0d en_busy got=%b exp=%b", c + 1, {bus.o_enable, bus.o_busy}, exp_eb[c]);
         end
         if (c < 2) tick();
      end
   endtask

   task automatic test_load_use();
      idle_inputs();
      bus.i_ex_valid = 1; bus.i_ex_load = 1; bus.i_ex_rd = 5;
      settle(); tick();
      bus.i_ex_valid = 0; bus.i_ex_load = 0;
      bus.i_id_valid = 1; bus.i_id_rs1 = 5; bus.i_id_rs2 = 1;
      for (int c = 0; c < 3; c++) begin
         settle();
         total++;
         if (bus.o_stall !== 1'b1) begin
            bad++;
            $display("FAIL load_use_wait%0d stall got=%b exp=1", c, bus.o_stall);
         end
         tick();
      end
      bus.i_wb_valid = 1; bus.i_wb_rd = 5;
      settle();
      total++;
      if (bus.o_stall !== 1'b0) begin
         bad++;
         $display("FAIL load_use_wb_cycle stall got=%b exp=0", bus.o_stall);
      end
      tick();
      bus.i_wb_valid = 0;
      settle();
      total++;
      if (bus.o_stall !== 1'b0) begin
         bad++;
         $display("FAIL load_use_after_wb stall got=%b exp=0", bus.o_stall);
      end
      tick();
      idle_inputs();
   endtask

   task automatic test_x0();
      idle_inputs();
      bus.i_ex_valid = 1; bus.i_ex_load = 1; bus.i_ex_rd = 0;
      bus.i_id_valid = 1; bus.i_id_rs1 = 0; bus.i_id_rs2 = 0;
      settle();
      total++;
      if (bus.o_stall !== 1'b0) begin
         bad++;
         $display("FAIL x0_ex stall got=%b exp=0", bus.o_stall);
      end
      tick();
      bus.i_ex_valid = 0; bus.i_ex_load = 0;
      settle();
      total++;
      if (bus.o_stall !== 1'b0 || dut.r_sb !== 32'd0) begin
         bad++;
         $display("FAIL x0_use stall=%b sb=%h exp stall=0 sb=0", bus.o_stall, dut.r_sb);
      end
      tick();
      idle_inputs();
   endtask

   task automatic test_redirect();
      idle_inputs();
      bus.i_redirect = 1;
      settle();
      total++;
      if (bus.o_flush !== 1'b0) begin
         bad++;
         $display("FAIL redirect_same_cycle flush got=%b exp=0", bus.o_flush);
      end
      tick();
      bus.i_redirect = 0;
      bus.i_ex_valid = 1; bus.i_ex_load = 1; bus.i_ex_rd = 9;
      bus.i_id_valid = 1; bus.i_id_rs1 = 9;
      settle();
      total++;
      if ({bus.o_flush, bus.o_stall, bus.o_busy} !== 3'b101) begin
         bad++;
         $display("FAIL redirect_flush flush_stall_busy got=%b exp=101", {bus.o_flush, bus.o_stall, bus.o_busy});
      end
      tick();
      bus.i_ex_valid = 0; bus.i_ex_load = 0;
      settle();
      total++;
      if ({bus.o_flush, bus.o_stall, bus.o_busy} !== 3'b000) begin
         bad++;
         $display("FAIL redirect_done flush_stall_busy got=%b exp=000", {bus.o_flush, bus.o_stall, bus.o_busy});
      end
      tick();
      idle_inputs();
   endtask

   task automatic test_trap_drain();
      int flush_cycles = 0;
      idle_inputs();
      bus.i_ex_valid = 1; bus.i_ex_load = 1; bus.i_ex_rd = 7;
      settle(); tick();
      bus.i_ex_valid = 0; bus.i_ex_load = 0;
      bus.i_trap = 1; bus.i_mem_idle = 0;
      settle(); tick();
      bus.i_trap = 0;
      bus.i_id_valid = 1; bus.i_id_rs1 = 7;
      for (int c = 0; c < 2; c++) begin
         settle();
         total++;
         if ({bus.o_flush, bus.o_stall, bus.o_busy} !== 3'b101) begin
            bad++;
            $display("FAIL trap_drain%0d flush_stall_busy got=%b exp=101", c, {bus.o_flush, bus.o_stall, bus.o_busy});
         end
         tick();
      end
      bus.i_wb_valid = 1; bus.i_wb_rd = 7; bus.i_mem_idle = 1;
      for (int c = 0; c < 6 && bus.o_busy; c++) begin
         settle();
         if (bus.o_busy) begin
            flush_cycles++;
            total++;
            if (bus.o_flush !== 1'b1) begin
               bad++;
               $display("FAIL trap_exit flush got=%b exp=1", bus.o_flush);
            end
            tick();
            bus.i_wb_valid = 0;
         end
      end
      total++;
      if (bus.o_busy !== 1'b0 || bus.o_flush !== 1'b0 || flush_cycles < 2) begin
         bad++;
         $display("FAIL trap_to_run busy=%b flush=%b tail=%0d exp busy=0 flush=0 tail>=2",
                  bus.o_busy, bus.o_flush, flush_cycles);
      end
      idle_inputs();
   endtask

   task automatic test_trap_redirect();
      idle_inputs();
      bus.i_trap = 1; bus.i_redirect = 1; bus.i_mem_idle = 0;
      settle(); tick();
      bus.i_trap = 0; bus.i_redirect = 0;
      for (int c = 0; c < 3; c++) begin
         settle();
         total++;
         if (bus.o_flush !== 1'b1) begin
            bad++;
            $display("FAIL trap_priority%0d flush got=%b exp=1", c, bus.o_flush);
         end
         tick();
      end
      bus.i_mem_idle = 1;
      for (int c = 0; c < 6 && m_mode != 1; c++) tick();
      settle();
      total++;
      if (bus.o_busy !== 1'b0) begin
         bad++;
         $display("FAIL trap_priority_exit busy got=%b exp=0", bus.o_busy);
      end
      idle_inputs();
   endtask

   task automatic test_reset_mid();
      idle_inputs();
      bus.i_ex_valid = 1; bus.i_ex_load = 1; bus.i_ex_rd = 3;
      settle(); tick();
      bus.i_ex_valid = 0; bus.i_ex_load = 0;
      bus.i_id_valid = 1; bus.i_id_rs1 = 3;
      #3 rst_n = 1'b0;
      #1;
      total++;
      if ({bus.o_enable, bus.o_stall, bus.o_flush, bus.o_busy} !== 4'b0001) begin
         bad++;
         $display("FAIL reset_mid got=%b exp=0001", {bus.o_enable, bus.o_stall, bus.o_flush, bus.o_busy});
      end
      idle_inputs();
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      wait_run("reset_mid");
      bus.i_id_valid = 1; bus.i_id_rs1 = 3;
      settle();
      total++;
      if (bus.o_stall !== 1'b0) begin
         bad++;
         $display("FAIL reset_mid_sb_cleared stall got=%b exp=0", bus.o_stall);
      end
      tick();
      idle_inputs();
   endtask

   task automatic test_random();
      for (int c = 0; c < 600; c++) begin
         bus.i_id_valid = ($urandom_range(0, 9) < 7);
         bus.i_id_rs1   = 5'($urandom_range(0, 7));
         bus.i_id_rs2   = 5'($urandom_range(0, 7));
         bus.i_ex_valid = ($urandom_range(0, 9) < 6);
         bus.i_ex_load  = ($urandom_range(0, 9) < 5);
         bus.i_ex_rd    = 5'($urandom_range(0, 7));
         bus.i_wb_valid = ($urandom_range(0, 9) < 3);
         bus.i_wb_rd    = 5'($urandom_range(0, 7));
         bus.i_redirect = ($urandom_range(0, 19) == 0);
         bus.i_trap     = ($urandom_range(0, 29) == 0);
         bus.i_mem_idle = ($urandom_range(0, 9) < 7);
         settle();
         total++;
         if ({bus.o_enable, bus.o_stall, bus.o_flush, bus.o_busy} !== {m_en, m_st, m_fl, m_busy}) begin
            bad++;
            $display("FAIL random_cyc%0d en_stall_flush_busy got=%b exp=%b", c,
                     {bus.o_enable, bus.o_stall, bus.o_flush, bus.o_busy}, {m_en, m_st, m_fl, m_busy});
         end
         tick();
      end
      idle_inputs();
   endtask

`ifdef RICE_CORE_HAZARD_STAT_EN
   task automatic test_stat();
      do_reset();
      wait_run("stat");
      total++;
      if (bus.o_stall_count !== 32'd0) begin
         bad++;
         $display("FAIL stat_reset count got=%0d exp=0", bus.o_stall_count);
      end
      bus.i_ex_valid = 1; bus.i_ex_load = 1; bus.i_ex_rd = 4;
      settle(); tick();
      bus.i_ex_valid = 0; bus.i_ex_load = 0;
      bus.i_id_valid = 1; bus.i_id_rs1 = 4;
      for (int c = 0; c < 3; c++) begin settle(); tick(); end
      idle_inputs();
      settle();
      total++;
      if (bus.o_stall_count !== 32'd3) begin
         bad++;
         $display("FAIL stat_three count got=%0d exp=3", bus.o_stall_count);
      end
      force dut.r_stall_count = 32'hFFFF_FFFF;
      #1;
      release dut.r_stall_count;
      bus.i_id_valid = 1; bus.i_id_rs1 = 4;
      settle(); tick();
      idle_inputs();
      settle();
      total++;
      if (bus.o_stall_count !== 32'hFFFF_FFFF) begin
         bad++;
         $display("FAIL stat_saturate count got=%h exp=ffffffff", bus.o_stall_count);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_load_use();
      test_x0();
      test_redirect();
      test_trap_drain();
      test_trap_redirect();
      test_reset_mid();
      test_random();
`ifdef RICE_CORE_HAZARD_STAT_EN
      test_stat();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end
endmodule
